// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lsu
//  Description : RV32 memory-stage load/store unit. Accepts one instruction
//                per in_valid/in_ready handshake, issues data-memory requests
//                over a valid/ready channel, aligns and sign/zero-extends load
//                data, and registers the writeback fields for MEM/WB.
//  Ports       :
//    clk, rst                 clock, synchronous active-high reset
//    in_*                     EX/MEM instruction fields and handshake
//    dmem_req_*               data-memory request channel (valid/ready)
//    dmem_rsp_valid/rdata     load response (one pulse per load request)
//    out_*                    registered writeback fields; out_valid pulses
//    stall                    inverse of in_ready
//  Revision    : 1.0  initial release
// ============================================================================
module mem_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // EX/MEM side
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_load,
    input  logic              in_is_store,
    input  logic [2:0]        in_funct3,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [4:0]        in_rd,
    input  logic              in_reg_we,
    // data-memory request
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_req_we,
    output logic [ADDR_W-1:0] dmem_req_addr,
    output logic [3:0]        dmem_req_be,
    output logic [DATA_W-1:0] dmem_req_wdata,
    // data-memory response
    input  logic              dmem_rsp_valid,
    input  logic [DATA_W-1:0] dmem_rsp_rdata,
    // MEM/WB side
    output logic              out_valid,
    output logic [4:0]        out_rd,
    output logic              out_reg_we,
    output logic [DATA_W-1:0] out_wdata,
    output logic              out_fault,
    output logic              stall
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;

    logic [1:0]        r_state;

    // Fields kept for the duration of an outstanding access
    logic [2:0]        r_funct3;
    logic [1:0]        r_addr_lo;
    logic [4:0]        r_rd;
    logic              r_reg_we;

    // Combinational decode of the incoming instruction
    logic              w_accept;
    logic              w_is_mem;
    logic              w_f3_illegal;
    logic              w_misaligned;
    logic              w_fault;
    logic [3:0]        w_st_be;
    logic [DATA_W-1:0] w_st_wdata;

    // Load alignment
    logic [DATA_W-1:0] w_lane;
    logic [DATA_W-1:0] w_load_data;

    // The unit only takes new work when nothing is outstanding.
    assign in_ready = (r_state == c_st_idle);
    assign stall    = ~in_ready;
    assign w_accept = in_valid & in_ready;
    assign w_is_mem = in_is_load | in_is_store;

    // ------------------------------------------------------------------------
    // Fault detection: funct3 legality depends on direction; alignment is
    // judged from the size field funct3[1:0] (BU/HU share size with B/H).
    // ------------------------------------------------------------------------
    always_comb begin
        w_f3_illegal = 1'b0;
        if (in_is_load) begin
            w_f3_illegal = (in_funct3 == 3'd3) || (in_funct3 == 3'd6) ||
                           (in_funct3 == 3'd7);
        end else if (in_is_store) begin
            w_f3_illegal = (in_funct3 > 3'd2);
        end
    end

    always_comb begin
        w_misaligned = 1'b0;
        case (in_funct3[1:0])
            2'b01:   w_misaligned = in_addr[0];
            2'b10:   w_misaligned = (in_addr[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
    end

    assign w_fault = w_is_mem & (w_f3_illegal | w_misaligned);

    // ------------------------------------------------------------------------
    // Store lane placement: the data is replicated across the word so that
    // the byte enables alone select the destination lane.
    // ------------------------------------------------------------------------
    always_comb begin
        w_st_be    = 4'b1111;
        w_st_wdata = in_wdata;
        case (in_funct3[1:0])
            2'b00: begin
                w_st_be    = 4'b0001 << in_addr[1:0];
                w_st_wdata = {4{in_wdata[7:0]}};
            end
            2'b01: begin
                w_st_be    = in_addr[1] ? 4'b1100 : 4'b0011;
                w_st_wdata = {2{in_wdata[15:0]}};
            end
            default: begin
                w_st_be    = 4'b1111;
                w_st_wdata = in_wdata;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Load alignment: shift the addressed byte/half down to bit 0, then
    // extend. funct3[2] set means unsigned (BU/HU).
    // ------------------------------------------------------------------------
    assign w_lane = dmem_rsp_rdata >> {r_addr_lo, 3'b000};

    always_comb begin
        w_load_data = w_lane;
        case (r_funct3[1:0])
            2'b00:   w_load_data = {{24{~r_funct3[2] & w_lane[7]}},  w_lane[7:0]};
            2'b01:   w_load_data = {{16{~r_funct3[2] & w_lane[15]}}, w_lane[15:0]};
            default: w_load_data = w_lane;
        endcase
    end

    // ------------------------------------------------------------------------
    // Control FSM and all registered outputs. out_valid is a one-cycle pulse;
    // the remaining out_* fields hold between pulses.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_st_idle;
            r_funct3       <= 3'd0;
            r_addr_lo      <= 2'd0;
            r_rd           <= 5'd0;
            r_reg_we       <= 1'b0;
            dmem_req_valid <= 1'b0;
            dmem_req_we    <= 1'b0;
            dmem_req_addr  <= '0;
            dmem_req_be    <= 4'd0;
            dmem_req_wdata <= '0;
            out_valid      <= 1'b0;
            out_rd         <= 5'd0;
            out_reg_we     <= 1'b0;
            out_wdata      <= '0;
            out_fault      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        if (!w_is_mem) begin
                            // ALU result passes straight through.
                            out_valid  <= 1'b1;
                            out_rd     <= in_rd;
                            out_reg_we <= in_reg_we;
                            out_wdata  <= in_alu_result;
                            out_fault  <= 1'b0;
                        end else if (w_fault) begin
                            // Faulting access completes without touching memory.
                            out_valid  <= 1'b1;
                            out_rd     <= in_rd;
                            out_reg_we <= 1'b0;
                            out_wdata  <= '0;
                            out_fault  <= 1'b1;
                        end else begin
                            r_state        <= c_st_req;
                            r_funct3       <= in_funct3;
                            r_addr_lo      <= in_addr[1:0];
                            r_rd           <= in_rd;
                            r_reg_we       <= in_reg_we;
                            dmem_req_valid <= 1'b1;
                            dmem_req_we    <= in_is_store;
                            dmem_req_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
                            dmem_req_be    <= in_is_store ? w_st_be : 4'b1111;
                            dmem_req_wdata <= in_is_store ? w_st_wdata : '0;
                        end
                    end
                end

                c_st_req: begin
                    // Request fields stay frozen until the memory takes them.
                    if (dmem_req_ready) begin
                        dmem_req_valid <= 1'b0;
                        if (dmem_req_we) begin
                            out_valid  <= 1'b1;
                            out_rd     <= r_rd;
                            out_reg_we <= 1'b0;
                            out_wdata  <= '0;
                            out_fault  <= 1'b0;
                            r_state    <= c_st_idle;
                        end else begin
                            r_state    <= c_st_wait;
                        end
                    end
                end

                c_st_wait: begin
                    if (dmem_rsp_valid) begin
                        out_valid  <= 1'b1;
                        out_rd     <= r_rd;
                        out_reg_we <= r_reg_we;
                        out_wdata  <= w_load_data;
                        out_fault  <= 1'b0;
                        r_state    <= c_st_idle;
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_lsu
//  Description : Self-checking bench for mem_lsu. Single-instruction vectors
//                with an always-ready memory are table driven; stalls,
//                back-to-back issue and reset recovery are hand sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_lsu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_load;
    logic        in_is_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [31:0] in_alu_result;
    logic [4:0]  in_rd;
    logic        in_reg_we;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_req_we;
    logic [31:0] dmem_req_addr;
    logic [3:0]  dmem_req_be;
    logic [31:0] dmem_req_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_rdata;
    logic        out_valid;
    logic [4:0]  out_rd;
    logic        out_reg_we;
    logic [31:0] out_wdata;
    logic        out_fault;
    logic        stall;

    int total = 0;
    int bad   = 0;

    mem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_is_load     (in_is_load),
        .in_is_store    (in_is_store),
        .in_funct3      (in_funct3),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .in_alu_result  (in_alu_result),
        .in_rd          (in_rd),
        .in_reg_we      (in_reg_we),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_req_we    (dmem_req_we),
        .dmem_req_addr  (dmem_req_addr),
        .dmem_req_be    (dmem_req_be),
        .dmem_req_wdata (dmem_req_wdata),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rsp_rdata (dmem_rsp_rdata),
        .out_valid      (out_valid),
        .out_rd         (out_rd),
        .out_reg_we     (out_reg_we),
        .out_wdata      (out_wdata),
        .out_fault      (out_fault),
        .stall          (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] alu, input logic [4:0] rd, input logic we);
        in_valid      = 1'b1;
        in_is_load    = ld;
        in_is_store   = st;
        in_funct3     = f3;
        in_addr       = addr;
        in_wdata      = wd;
        in_alu_result = alu;
        in_rd         = rd;
        in_reg_we     = we;
    endtask

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] rdata;
        int          lat;
        logic        e_fault;
        logic        e_we;
        logic [31:0] e_wb;
        logic        e_req;
        logic [3:0]  e_be;
        logic [31:0] e_sd;
    } vec_t;

    // One instruction against an always-ready memory that answers loads the
    // cycle after the request handshake.
    task automatic run_vec(input int idx, input vec_t v);
        bit got_out;
        bit got_req;
        bit rsp_next;
        @(negedge clk);
        dmem_req_ready = 1'b1;
        chk($sformatf("v%0d in_ready", idx), {31'd0, in_ready}, 32'd1);
        drive(v.ld, v.st, v.f3, v.addr, v.wd, v.alu, v.rd, v.we);
        @(posedge clk);
        got_out  = 1'b0;
        got_req  = 1'b0;
        rsp_next = 1'b0;
        for (int cyc = 1; cyc <= 8 && !got_out; cyc++) begin
            @(negedge clk);
            in_valid       = 1'b0;
            dmem_rsp_valid = 1'b0;
            if (rsp_next) begin
                dmem_rsp_valid = 1'b1;
                dmem_rsp_rdata = v.rdata;
                rsp_next       = 1'b0;
            end
            if (out_valid) begin
                got_out = 1'b1;
                chk($sformatf("v%0d latency", idx), cyc, v.lat);
                chk($sformatf("v%0d out_rd", idx), {27'd0, out_rd}, {27'd0, v.rd});
                chk($sformatf("v%0d out_fault", idx), {31'd0, out_fault}, {31'd0, v.e_fault});
                chk($sformatf("v%0d out_reg_we", idx), {31'd0, out_reg_we}, {31'd0, v.e_we});
                if (v.e_we)
                    chk($sformatf("v%0d out_wdata", idx), out_wdata, v.e_wb);
            end
            if (dmem_req_valid && !got_req) begin
                got_req = 1'b1;
                chk($sformatf("v%0d req_addr", idx), dmem_req_addr, {v.addr[31:2], 2'b00});
                chk($sformatf("v%0d req_be", idx), {28'd0, dmem_req_be}, {28'd0, v.e_be});
                chk($sformatf("v%0d req_we", idx), {31'd0, dmem_req_we}, {31'd0, v.st});
                if (v.st)
                    chk($sformatf("v%0d req_wdata", idx), dmem_req_wdata, v.e_sd);
                if (!v.st)
                    rsp_next = 1'b1;
            end
            @(posedge clk);
        end
        if (!got_out) begin
            total++;
            bad++;
            $display("FAIL v%0d out_valid: got none expected pulse within 8 cycles", idx);
        end
        chk($sformatf("v%0d req_seen", idx), {31'd0, got_req}, {31'd0, v.e_req});
        @(negedge clk);
        chk($sformatf("v%0d pulse_once", idx), {31'd0, out_valid}, 32'd0);
    endtask

    vec_t vecs[14];

    initial begin
        //          ld st f3   addr          wd            alu          rd  we rdata         lat flt ewe wb            req be       sd
        vecs[0]  = '{0, 0, 3'd0, 32'h0000_0000, 32'h0,        32'h0000_1234, 5, 1, 32'h0,        1, 0, 1, 32'h0000_1234, 0, 4'h0,    32'h0};
        vecs[1]  = '{1, 0, 3'd0, 32'h0000_0103, 32'h0,        32'h0,        6, 1, 32'h80FF_0000, 3, 0, 1, 32'hFFFF_FF80, 1, 4'hF,    32'h0};
        vecs[2]  = '{1, 0, 3'd4, 32'h0000_0103, 32'h0,        32'h0,        7, 1, 32'h80FF_0000, 3, 0, 1, 32'h0000_0080, 1, 4'hF,    32'h0};
        vecs[3]  = '{1, 0, 3'd1, 32'h0000_0102, 32'h0,        32'h0,        8, 1, 32'h8001_7FFF, 3, 0, 1, 32'hFFFF_8001, 1, 4'hF,    32'h0};
        vecs[4]  = '{1, 0, 3'd5, 32'h0000_0100, 32'h0,        32'h0,        9, 1, 32'h1234_F00D, 3, 0, 1, 32'h0000_F00D, 1, 4'hF,    32'h0};
        vecs[5]  = '{1, 0, 3'd2, 32'h0000_0040, 32'h0,        32'h0,       10, 1, 32'hDEAD_BEEF, 3, 0, 1, 32'hDEAD_BEEF, 1, 4'hF,    32'h0};
        vecs[6]  = '{0, 1, 3'd0, 32'h0000_0301, 32'h1234_56A5, 32'h0,       11, 1, 32'h0,        2, 0, 0, 32'h0,        1, 4'b0010, 32'hA5A5_A5A5};
        vecs[7]  = '{0, 1, 3'd2, 32'h0000_0404, 32'hCAFE_F00D, 32'h0,       12, 0, 32'h0,        2, 0, 0, 32'h0,        1, 4'hF,    32'hCAFE_F00D};
        vecs[8]  = '{0, 1, 3'd1, 32'h0000_0200, 32'h0000_1357, 32'h0,       13, 0, 32'h0,        2, 0, 0, 32'h0,        1, 4'b0011, 32'h1357_1357};
        vecs[9]  = '{1, 0, 3'd2, 32'h0000_0101, 32'h0,        32'h0,       14, 1, 32'h0,        1, 1, 0, 32'h0,        0, 4'h0,    32'h0};
        vecs[10] = '{1, 0, 3'd1, 32'h0000_0003, 32'h0,        32'h0,       15, 1, 32'h0,        1, 1, 0, 32'h0,        0, 4'h0,    32'h0};
        vecs[11] = '{1, 0, 3'd3, 32'h0000_0000, 32'h0,        32'h0,       16, 1, 32'h0,        1, 1, 0, 32'h0,        0, 4'h0,    32'h0};
        vecs[12] = '{0, 1, 3'd4, 32'h0000_0000, 32'h0,        32'h0,       17, 0, 32'h0,        1, 1, 0, 32'h0,        0, 4'h0,    32'h0};
        vecs[13] = '{1, 0, 3'd0, 32'h0000_0102, 32'h0,        32'h0,       18, 1, 32'h0055_0000, 3, 0, 1, 32'h0000_0055, 1, 4'hF,    32'h0};

        rst            = 1'b1;
        in_valid       = 1'b0;
        in_is_load     = 1'b0;
        in_is_store    = 1'b0;
        in_funct3      = 3'd0;
        in_addr        = 32'd0;
        in_wdata       = 32'd0;
        in_alu_result  = 32'd0;
        in_rd          = 5'd0;
        in_reg_we      = 1'b0;
        dmem_req_ready = 1'b1;
        dmem_rsp_valid = 1'b0;
        dmem_rsp_rdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst in_ready",  {31'd0, in_ready},       32'd1);
        chk("rst stall",     {31'd0, stall},          32'd0);
        chk("rst req_valid", {31'd0, dmem_req_valid}, 32'd0);
        chk("rst req_addr",  dmem_req_addr,           32'd0);
        chk("rst out_valid", {31'd0, out_valid},      32'd0);
        chk("rst out_wdata", out_wdata,               32'd0);
        chk("rst out_rd",    {27'd0, out_rd},         32'd0);

        for (int i = 0; i < 14; i++)
            run_vec(i, vecs[i]);

        // SH with the memory holding ready low for three cycles, while the
        // next (ALU) instruction waits upstream.
        @(negedge clk);
        dmem_req_ready = 1'b0;
        drive(0, 1, 3'd1, 32'h0000_0202, 32'hAAAA_BEEF, 32'h0, 5'd20, 1'b0);
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) drive(0, 0, 3'd0, 32'h0, 32'h0, 32'h0000_0099, 5'd9, 1'b1);
            chk($sformatf("sh c%0d req_valid", c), {31'd0, dmem_req_valid}, 32'd1);
            chk($sformatf("sh c%0d req_addr", c),  dmem_req_addr, 32'h0000_0200);
            chk($sformatf("sh c%0d req_be", c),    {28'd0, dmem_req_be}, 32'h0000_000C);
            chk($sformatf("sh c%0d req_wdata", c), dmem_req_wdata, 32'hBEEF_BEEF);
            chk($sformatf("sh c%0d stall", c),     {31'd0, stall}, 32'd1);
            chk($sformatf("sh c%0d out_valid", c), {31'd0, out_valid}, 32'd0);
            if (c == 4) dmem_req_ready = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        chk("sh out_valid",  {31'd0, out_valid},      32'd1);
        chk("sh out_reg_we", {31'd0, out_reg_we},     32'd0);
        chk("sh out_rd",     {27'd0, out_rd},         32'd20);
        chk("sh req_drop",   {31'd0, dmem_req_valid}, 32'd0);
        chk("sh in_ready",   {31'd0, in_ready},       32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("sh next out_valid", {31'd0, out_valid}, 32'd1);
        chk("sh next out_rd",    {27'd0, out_rd},    32'd9);
        chk("sh next out_wdata", out_wdata,          32'h0000_0099);

        // Misaligned LW immediately followed by an ALU op
        @(negedge clk);
        drive(1, 0, 3'd2, 32'h0000_0101, 32'h0, 32'h0, 5'd21, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("flt out_valid",  {31'd0, out_valid},      32'd1);
        chk("flt out_fault",  {31'd0, out_fault},      32'd1);
        chk("flt out_reg_we", {31'd0, out_reg_we},     32'd0);
        chk("flt no_req",     {31'd0, dmem_req_valid}, 32'd0);
        chk("flt in_ready",   {31'd0, in_ready},       32'd1);
        drive(0, 0, 3'd0, 32'h0, 32'h0, 32'h0000_0007, 5'd7, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("flt next out_valid", {31'd0, out_valid}, 32'd1);
        chk("flt next out_rd",    {27'd0, out_rd},    32'd7);
        chk("flt next out_fault", {31'd0, out_fault}, 32'd0);
        chk("flt next out_wdata", out_wdata,          32'h0000_0007);

        // Back-to-back ALU, LW, ALU
        @(negedge clk);
        dmem_req_ready = 1'b1;
        drive(0, 0, 3'd0, 32'h0, 32'h0, 32'h0000_0011, 5'd1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("b2b alu1 valid", {31'd0, out_valid}, 32'd1);
        chk("b2b alu1 rd",    {27'd0, out_rd},    32'd1);
        drive(1, 0, 3'd2, 32'h0000_0040, 32'h0, 32'h0, 5'd2, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("b2b lw req",     {31'd0, dmem_req_valid}, 32'd1);
        chk("b2b lw busy",    {31'd0, out_valid},      32'd0);
        drive(0, 0, 3'd0, 32'h0, 32'h0, 32'h0000_0033, 5'd3, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("b2b wait stall", {31'd0, in_ready},  32'd0);
        chk("b2b wait quiet", {31'd0, out_valid}, 32'd0);
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        chk("b2b lw valid",  {31'd0, out_valid}, 32'd1);
        chk("b2b lw rd",     {27'd0, out_rd},    32'd2);
        chk("b2b lw wdata",  out_wdata,          32'hDEAD_BEEF);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b alu2 valid", {31'd0, out_valid}, 32'd1);
        chk("b2b alu2 rd",    {27'd0, out_rd},    32'd3);
        chk("b2b alu2 wdata", out_wdata,          32'h0000_0033);

        // Reset while waiting for a load response, then a stray response
        @(negedge clk);
        drive(1, 0, 3'd2, 32'h0000_0040, 32'h0, 32'h0, 5'd4, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstw in_wait", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rstw in_ready",  {31'd0, in_ready},       32'd1);
        chk("rstw req_valid", {31'd0, dmem_req_valid}, 32'd0);
        chk("rstw out_valid", {31'd0, out_valid},      32'd0);
        chk("rstw out_wdata", out_wdata,               32'd0);
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'h1111_2222;
        @(posedge clk);
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        chk("stray out_valid", {31'd0, out_valid}, 32'd0);
        chk("stray in_ready",  {31'd0, in_ready},  32'd1);
        chk("stray out_wdata", out_wdata,          32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
